// File: rtl/mmio_hub.sv
// Peripheral hub for the processor data port: address decode, RAM/peripheral read mux,
// Galois LFSR RNG, dot-update FIFO toward VGA, generation counter and status register.
module mmio_hub #(
  parameter int unsigned          DATA_W     = 32,
  parameter int unsigned          STAT_ADDR  = 97,
  parameter int unsigned          GEN_ADDR   = 98,
  parameter int unsigned          RNG_ADDR   = 99,
  parameter int unsigned          DOT_BASE   = 100,
  parameter int unsigned          NUM_DOTS   = 450,
  parameter int unsigned          FIFO_DEPTH = 8,
  parameter logic [DATA_W-1:0]    LFSR_TAPS  = 32'h80200003,
  parameter logic [DATA_W-1:0]    LFSR_SEED  = 32'h0000ACE1,
  parameter int unsigned          CNT_W      = 14,
  localparam int unsigned         ID_W       = $clog2(NUM_DOTS),
  localparam int unsigned         PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] q_dmem,
  input  logic              inc_gen,
  output logic              dot_valid,
  input  logic              dot_ready,
  output logic              dot_is_y,
  output logic [ID_W-1:0]   dot_id,
  output logic [DATA_W-1:0] dot_loc,
  output logic [CNT_W-1:0]  gen_count,
  output logic              fifo_overflow
);

  localparam logic [DATA_W-1:0] STAT_A = DATA_W'(STAT_ADDR);
  localparam logic [DATA_W-1:0] GEN_A  = DATA_W'(GEN_ADDR);
  localparam logic [DATA_W-1:0] RNG_A  = DATA_W'(RNG_ADDR);
  localparam logic [DATA_W-1:0] DOT_LO = DATA_W'(DOT_BASE);
  localparam logic [DATA_W-1:0] DOT_Y  = DATA_W'(DOT_BASE + NUM_DOTS);
  localparam logic [DATA_W-1:0] DOT_HI = DATA_W'(DOT_BASE + 2 * NUM_DOTS);
  localparam logic [PTR_W:0]    LVL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {SEL_RAM, SEL_PERIPH} rd_sel_e;

  typedef struct packed {
    logic              is_y;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] loc;
  } dot_t;

  rd_sel_e           rd_sel;
  logic [DATA_W-1:0] rd_snap, snap_next, stat_val, lfsr;
  logic              periph_hit;
  logic              in_dot, is_y;
  logic [ID_W-1:0]   id;
  logic              wr_stat, wr_gen, wr_rng;

  dot_t              mem [FIFO_DEPTH];
  dot_t              head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              full, empty, push_req, push_ok, pop, ovf_set;

  always_comb begin
    in_dot  = (addr >= DOT_LO) && (addr < DOT_HI);
    is_y    = addr >= DOT_Y;
    id      = ID_W'(is_y ? addr - DOT_Y : addr - DOT_LO);
    wr_stat = wren && (addr == STAT_A);
    wr_gen  = wren && (addr == GEN_A);
    wr_rng  = wren && (addr == RNG_A);
  end

  always_comb begin
    full     = count == LVL_FULL;
    empty    = count == '0;
    push_req = wren && in_dot;
    pop      = !empty && dot_ready;
    // a full FIFO still accepts a push when the head leaves on the same edge
    push_ok  = push_req && (!full || pop);
    ovf_set  = push_req && full && !pop;
  end

  always_comb begin
    stat_val              = '0;
    stat_val[DATA_W-1]    = fifo_overflow;
    stat_val[DATA_W-2]    = full;
    stat_val[DATA_W-3]    = empty;
    stat_val[PTR_W:0]     = count;
  end

  always_comb begin
    periph_hit = 1'b1;
    snap_next  = '0;
    if (addr == STAT_A)     snap_next = stat_val;
    else if (addr == GEN_A) snap_next = DATA_W'(gen_count);
    else if (addr == RNG_A) snap_next = lfsr;
    else                    periph_hit = 1'b0;
  end

  // Snapshot matches the RAM's one-cycle read latency so the mux switches in lockstep.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_sel  <= SEL_RAM;
      rd_snap <= '0;
    end else begin
      rd_sel  <= periph_hit ? SEL_PERIPH : SEL_RAM;
      rd_snap <= snap_next;
    end
  end

  assign q_dmem = (rd_sel == SEL_PERIPH) ? rd_snap : ram_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr <= LFSR_SEED;
    end else if (wr_rng) begin
      lfsr <= (wdata == '0) ? LFSR_SEED : wdata;
    end else begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gen_count <= '0;
    end else if (wr_gen) begin
      gen_count <= wdata[CNT_W-1:0];
    end else if (inc_gen) begin
      gen_count <= gen_count + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fifo_overflow <= 1'b0;
    end else if (ovf_set) begin
      fifo_overflow <= 1'b1;
    end else if (wr_stat && wdata[DATA_W-1]) begin
      fifo_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= '{is_y: is_y, id: id, loc: wdata};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
    end
  end

  // Head fields are forced to zero while empty so storage needs no reset.
  always_comb begin
    head      = mem[rd_ptr];
    dot_valid = !empty;
    dot_is_y  = !empty && head.is_y;
    dot_id    = empty ? '0 : head.id;
    dot_loc   = empty ? '0 : head.loc;
  end

endmodule

// File: tb/tb_mmio_hub.sv
// Randomised scoreboard bench for mmio_hub: a transaction-level model queues expected
// read data and dot entries; a negedge monitor pops and compares them.
module tb_mmio_hub;

  localparam logic [31:0] SEED = 32'h0000ACE1;
  localparam logic [31:0] TAPS = 32'h80200003;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0, wdata = '0, ram_q = '0;
  logic        wren = 1'b0, inc_gen = 1'b0, dot_ready = 1'b0;
  logic [31:0] q_dmem, dot_loc;
  logic        dot_valid, dot_is_y, fifo_overflow;
  logic [8:0]  dot_id;
  logic [13:0] gen_count;

  always #5 clock = ~clock;

  mmio_hub #(
    .DATA_W(32), .FIFO_DEPTH(8), .NUM_DOTS(450), .CNT_W(14)
  ) dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .wren(wren),
    .ram_q(ram_q), .q_dmem(q_dmem), .inc_gen(inc_gen), .dot_valid(dot_valid),
    .dot_ready(dot_ready), .dot_is_y(dot_is_y), .dot_id(dot_id), .dot_loc(dot_loc),
    .gen_count(gen_count), .fifo_overflow(fifo_overflow)
  );

  typedef struct { bit y; int id; logic [31:0] loc; } dot_s;
  typedef struct { bit ram; logic [31:0] v; } rd_s;

  dot_s        dot_exp[$];
  rd_s         rd_exp[$];
  int          lvl_m = 0;
  bit          ovf_m = 0;
  int          gen_m = 0;
  logic [31:0] lfsr_m = SEED;
  int          n_vec = 0, n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: whole-transaction view of each clock edge.
  always @(posedge clock or negedge reset) begin
    longint unsigned a;
    bit   win, pop, set_now;
    rd_s  r;
    dot_s e;
    if (!reset) begin
      lvl_m = 0; ovf_m = 0; gen_m = 0; lfsr_m = SEED;
      dot_exp.delete(); rd_exp.delete();
    end else begin
      a = addr;
      r.ram = 0;
      if (a == 97)
        r.v = (ovf_m ? 32'h8000_0000 : 0) | (lvl_m == 8 ? 32'h4000_0000 : 0)
            | (lvl_m == 0 ? 32'h2000_0000 : 0) | 32'(lvl_m);
      else if (a == 98) r.v = 32'(gen_m);
      else if (a == 99) r.v = lfsr_m;
      else begin r.ram = 1; r.v = '0; end
      rd_exp.push_back(r);

      win = (a >= 100) && (a < 1000);
      pop = (lvl_m > 0) && dot_ready;
      set_now = 0;
      if (wren && win) begin
        if (lvl_m == 8 && !pop) begin
          ovf_m = 1; set_now = 1;
        end else begin
          e.y = (a >= 550); e.id = e.y ? int'(a - 550) : int'(a - 100); e.loc = wdata;
          dot_exp.push_back(e);
          lvl_m++;
        end
      end
      if (pop) lvl_m--;
      if (wren && a == 97 && wdata[31] && !set_now) ovf_m = 0;

      if (wren && a == 98) gen_m = int'(wdata % 16384);
      else if (inc_gen)    gen_m = (gen_m + 1) % 16384;

      if (wren && a == 99) lfsr_m = (wdata == 0) ? SEED : wdata;
      else                 lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? TAPS : 32'h0);
    end
  end

  always @(negedge clock) begin
    rd_s  r;
    dot_s e;
    logic [31:0] exp_q;
    exp_q = ram_q;
    if (rd_exp.size() > 0) begin
      r = rd_exp.pop_front();
      if (!r.ram) exp_q = r.v;
    end
    check("q_dmem", q_dmem, exp_q);
    check("dot_valid", 32'(dot_valid), 32'(lvl_m != 0));
    check("gen_count", 32'(gen_count), 32'(gen_m));
    check("fifo_overflow", 32'(fifo_overflow), 32'(ovf_m));
    if (lvl_m != 0 && dot_ready) begin
      if (dot_exp.size() == 0) begin
        check("dot_queue_underrun", 32'(dot_exp.size()), 32'd1);
      end else begin
        e = dot_exp.pop_front();
        check("dot_is_y", 32'(dot_is_y), 32'(e.y));
        check("dot_id", 32'(dot_id), 32'(e.id));
        check("dot_loc", dot_loc, e.loc);
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input bit we,
                       input bit inc, input bit rdy);
    addr = a; wdata = d; wren = we; inc_gen = inc; dot_ready = rdy; ram_q = $urandom;
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) drive($urandom_range(0, 96), $urandom, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    logic [31:0] a, d;
    int sel;

    idle(3, 0);
    reset = 1'b1;
    idle(2, 0);

    // dot store ordering, X then Y, no bypass
    drive(100, 7, 1, 0, 0);
    drive(551, 9, 1, 0, 0);
    idle(2, 0);
    idle(3, 1);

    // overflow on ninth store, then write-1-to-clear
    for (int i = 0; i < 9; i++) drive($urandom_range(100, 999), $urandom, 1, 0, 0);
    drive(97, '0, 0, 0, 0);
    drive(97, 32'h8000_0000, 1, 0, 0);
    drive(97, '0, 0, 0, 0);
    idle(10, 1);

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) drive($urandom_range(100, 999), $urandom, 1, 0, 0);
    drive(999, 32'hDEAD_BEEF, 1, 0, 1);
    drive(97, '0, 0, 0, 0);
    idle(10, 1);

    // RNG read-back and reseed
    repeat (3) drive(99, '0, 0, 0, 0);
    drive(99, '0, 1, 0, 0);
    repeat (3) drive(99, '0, 0, 0, 0);
    drive(99, 32'h1234_5679, 1, 0, 0);
    repeat (2) drive(99, '0, 0, 0, 0);

    // generation counter wrap and write-beats-increment
    drive(98, 16383, 1, 0, 0);
    drive(98, '0, 0, 1, 0);
    drive(98, 5, 1, 1, 0);
    drive(98, '0, 0, 0, 0);
    drive(98, '0, 0, 0, 0);

    // randomised mix across every address class
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1:    a = $urandom_range(0, 96);
        2:       a = $urandom_range(1000, 100000);
        3:       a = 97;
        4:       a = 98;
        5:       a = 99;
        6:       a = ($urandom_range(0, 1) == 1) ? 32'd549 : 32'd550;
        7:       a = ($urandom_range(0, 1) == 1) ? 32'd100 : 32'd999;
        default: a = $urandom_range(100, 999);
      endcase
      d = $urandom;
      if (a == 99 && $urandom_range(0, 3) == 0) d = '0;
      drive(a, d, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0);
    end
    idle(12, 1);

    // asynchronous reset mid-run with three queued dots
    drive(98, 123, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive($urandom_range(100, 999), $urandom, 1, 0, 0);
    drive(97, '0, 1, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("reset_dot_valid", 32'(dot_valid), 32'd0);
    check("reset_gen_count", 32'(gen_count), 32'd0);
    check("reset_overflow", 32'(fifo_overflow), 32'd0);
    check("reset_q_dmem", q_dmem, ram_q);
    check("reset_dot_loc", dot_loc, 32'd0);
    @(posedge clock); #1;
    idle(2, 0);
    reset = 1'b1;
    drive(99, '0, 0, 0, 0);
    #3;
    check("rng_after_reset", q_dmem, SEED);
    @(posedge clock); #1;
    idle(3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
